v_xfer_sched: RTL and testbench
===============================

// Module: v_xfer_sched
// PURPOSE
//  Multi-outstanding transfer scheduler for the DMA engine: selects the next channel/direction
//  from per-channel pending flags using priority + round-robin, offers it to the AHB transfer
//  unit over a valid/ready handshake, and tracks up to MAX_OUTST issued bursts in order so that
//  completion/error responses are routed back to the owning channel.
//  Sits between the v_channel array and the AHB master; replaces single-register ch tracking.
// PARAMETERS
//  CHANNEL_NUM  8  number of DMA channels (>=2)
//  PRIO_W       2  priority field width; higher value wins
//  MAX_OUTST    4  depth of in-order outstanding-burst tracker (power of 2, >=2)
//  WRITE_FIRST  1  1: write request beats read on the same cycle; 0: read beats write
// PORTS
//  clk            in   1                       clock
//  areset         in   1                       async reset, active-low
//  ch_enable_i    in   CHANNEL_NUM             channel enabled
//  ch_prior_i     in   CHANNEL_NUM x PRIO_W    channel priority
//  ch_rd_pend_i   in   CHANNEL_NUM             channel has a qualified read burst ready
//  ch_wr_pend_i   in   CHANNEL_NUM             channel has a qualified write burst ready
//  xfer_valid_o   out  1                       burst offer valid
//  xfer_ready_i   in   1                       transfer unit accepts offer
//  xfer_ch_o      out  $clog2(CHANNEL_NUM)     offered channel
//  xfer_dir_o     out  1                       0 read, 1 write
//  done_i         in   1                       oldest outstanding burst completed (1-cycle pulse)
//  resp_err_i     in   1                       qualifies done_i: burst ended in ERROR response
//  done_valid_o   out  1                       registered completion strobe to channel
//  done_ch_o      out  $clog2(CHANNEL_NUM)     channel of completed burst
//  done_dir_o     out  1                       direction of completed burst
//  ch_err_o       out  CHANNEL_NUM             sticky per-channel bus error
//  proto_err_o    out  1                       sticky: done_i with empty tracker
//  outst_cnt_o    out  $clog2(MAX_OUTST)+1     bursts in flight
//  idle_o         out  1                       FSM in IDLE and tracker empty
// BEHAVIOUR
//  Reset: FSM=IDLE, all outputs 0, tracker empty, RR pointer 0, ch_err_o 0.
//  Eligible(i,d) = ch_enable_i[i] & pend[d][i] & ~ch_err_o[i] & no tracker entry with (i,d).
//  Direction select: if both dirs have eligibles, WRITE_FIRST decides; else the one present.
//  Channel select in chosen dir: max ch_prior_i; ties -> first index at/after rr_ptr (wrapping).
//  FSM:
//   IDLE : ~|ch_enable_i & tracker empty. Leave to ARB when any enable set.
//   ARB  : if tracker full or no eligible -> stay; else register (ch,dir) -> OFFER.
//          If ~|ch_enable_i and tracker empty -> IDLE.
//   OFFER: xfer_valid_o=1, xfer_ch_o/xfer_dir_o stable until handshake.
//          valid&ready -> push (ch,dir), rr_ptr<=ch+1 (wrap at CHANNEL_NUM), -> ARB.
//          Offered channel disabled before accept -> drop valid next cycle, -> ARB (only
//          permitted valid withdrawal).
//  Throughput: one offer per 2 cycles; ARB->valid latency 1 cycle.
//  Tracker: in-order FIFO, MAX_OUTST entries; outst_cnt_o = occupancy.
//   done_i pops head; next cycle done_valid_o=1 with head ch/dir.
//   done_i & resp_err_i -> ch_err_o[head.ch] set; cleared only when ch_enable_i of that ch=0.
//   Push and pop same cycle: count unchanged, both take effect; legal even when full.
//   done_i on empty tracker: ignored, proto_err_o<=1 (cleared only by reset).
//   Channel disabled with entries in flight: entries still drain and report normally.
//  Priority/pend inputs sampled only in ARB; changes during OFFER have no effect.
// STRUCTURE
//  Package v_sched_pkg: fsm_state_e {IDLE,ARB,OFFER}, xfer_dir_e {DIR_RD,DIR_WR},
//   typedef trk_entry_t {ch, dir}.
//  Sub-module v_prio_rr_arb #(N,PRIO_W): comb, inputs req/prio/rr_ptr, outputs gnt_idx/gnt_vld;
//   instanced twice (read, write). Tracker FIFO and FSM live in v_xfer_sched.
// TESTING
//  1 ch2 rd_pend, prio all 0 -> ARB, next cycle valid ch=2 dir=0; ready=1 -> outst_cnt_o=1.
//  2 ch1,ch5 both rd_pend prio 3 vs 1 -> ch1 first; with equal prio, 4 grants alternate 1,5,1,5.
//  3 ch0 rd_pend and ch3 wr_pend, WRITE_FIRST=1 -> ch3/dir1 first; WRITE_FIRST=0 -> ch0/dir0.
//  4 issue 4 bursts (MAX_OUTST=4), no done -> valid stays 0; one done_i -> next offer proceeds.
//  5 done_i+resp_err_i for head ch6 -> done_valid_o, ch_err_o[6]=1, ch6 never offered until
//    ch_enable_i[6] toggled low.
//  6 done_i with tracker empty -> proto_err_o=1, counts unchanged; areset low mid-OFFER ->
//    all outputs 0 same cycle.

Source files
------------

// File: rtl/v_sched_pkg.sv
// Shared types for the DMA transfer scheduler: FSM states, transfer direction
// and the in-order outstanding-burst tracker entry.
package v_sched_pkg;

    // Widest channel index a tracker entry can hold (up to 256 channels).
    localparam int CH_W_MAX = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        OFFER = 2'd2
    } fsm_state_e;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } xfer_dir_e;

    typedef struct packed {
        logic [CH_W_MAX-1:0] ch;
        xfer_dir_e           dir;
    } trk_entry_t;

endpackage

// File: rtl/v_prio_rr_arb.sv
// Combinational priority arbiter: the highest prio value wins, and ties go to
// the first requester found scanning upward from rr_ptr with wrap-around.
module v_prio_rr_arb #(
    parameter int  N      = 8,
    parameter int  PRIO_W = 2,
    localparam int IDX_W  = $clog2(N)
) (
    input  logic [N-1:0]             req,
    input  logic [N-1:0][PRIO_W-1:0] prio,
    input  logic [IDX_W-1:0]         rr_ptr,
    output logic [IDX_W-1:0]         gnt_idx,
    output logic                     gnt_vld
);

    logic [PRIO_W-1:0] max_prio_s;
    logic [IDX_W-1:0]  scan_idx_s;
    int                scan_s;

    // Highest priority value among the active requesters.
    always_comb begin
        max_prio_s = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && (prio[i] > max_prio_s)) begin
                max_prio_s = prio[i];
            end else begin
                max_prio_s = max_prio_s;
            end
        end
    end

    // First top-priority requester at or after rr_ptr, wrapping at N.
    always_comb begin
        gnt_idx    = '0;
        gnt_vld    = 1'b0;
        scan_s     = '0;
        scan_idx_s = '0;
        for (int k = 0; k < N; k++) begin
            scan_s = int'(rr_ptr) + k;
            if (scan_s >= N) begin
                scan_s = scan_s - N;
            end else begin
                scan_s = scan_s;
            end
            scan_idx_s = IDX_W'(scan_s);
            if (!gnt_vld && req[scan_idx_s] && (prio[scan_idx_s] == max_prio_s)) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx_s;
            end else begin
                gnt_vld = gnt_vld;
            end
        end
    end

endmodule

// File: rtl/v_xfer_sched.sv
// DMA transfer scheduler: picks the next channel/direction, offers it over a
// valid/ready handshake and routes in-order completions back to the channel.
module v_xfer_sched
    import v_sched_pkg::*;
#(
    parameter int  CHANNEL_NUM = 8,
    parameter int  PRIO_W      = 2,
    parameter int  MAX_OUTST   = 4,
    parameter bit  WRITE_FIRST = 1'b1,
    localparam int IDX_W       = $clog2(CHANNEL_NUM),
    localparam int CNT_W       = $clog2(MAX_OUTST) + 1
) (
    input  logic                               clk,
    input  logic                               areset,
    input  logic [CHANNEL_NUM-1:0]             ch_enable_i,
    input  logic [CHANNEL_NUM-1:0][PRIO_W-1:0] ch_prior_i,
    input  logic [CHANNEL_NUM-1:0]             ch_rd_pend_i,
    input  logic [CHANNEL_NUM-1:0]             ch_wr_pend_i,
    output logic                               xfer_valid_o,
    input  logic                               xfer_ready_i,
    output logic [IDX_W-1:0]                   xfer_ch_o,
    output logic                               xfer_dir_o,
    input  logic                               done_i,
    input  logic                               resp_err_i,
    output logic                               done_valid_o,
    output logic [IDX_W-1:0]                   done_ch_o,
    output logic                               done_dir_o,
    output logic [CHANNEL_NUM-1:0]             ch_err_o,
    output logic                               proto_err_o,
    output logic [CNT_W-1:0]                   outst_cnt_o,
    output logic                               idle_o
);

    localparam int               PTR_W    = $clog2(MAX_OUTST);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNEL_NUM - 1);

    fsm_state_e             state_r, state_nxt_s;
    logic [IDX_W-1:0]       rr_ptr_r, off_ch_r;
    xfer_dir_e              off_dir_r;
    logic                   xfer_valid_r, idle_r;

    trk_entry_t             trk_mem_r [MAX_OUTST];
    logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r, off_s;
    logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
    trk_entry_t             head_s;
    logic                   push_s, pop_s, load_s, full_s, empty_s;

    logic [CHANNEL_NUM-1:0] busy_rd_s, busy_wr_s, elig_rd_s, elig_wr_s;
    logic [CHANNEL_NUM-1:0] ch_err_r, err_set_s;
    logic [IDX_W-1:0]       rd_idx_s, wr_idx_s, sel_ch_s;
    logic                   rd_vld_s, wr_vld_s, sel_vld_s;
    xfer_dir_e              sel_dir_s;

    logic                   done_valid_r, done_dir_r, proto_err_r;
    logic [IDX_W-1:0]       done_ch_r;

    assign full_s  = (cnt_r == CNT_FULL);
    assign empty_s = (cnt_r == '0);
    assign pop_s   = done_i && !empty_s;
    assign head_s  = trk_mem_r[rd_ptr_r];

    // Mark every (channel, direction) pair that already has a burst in flight.
    always_comb begin
        busy_rd_s = '0;
        busy_wr_s = '0;
        off_s     = '0;
        for (int k = 0; k < MAX_OUTST; k++) begin
            off_s = PTR_W'(k) - rd_ptr_r;
            if ({1'b0, off_s} < cnt_r) begin
                if (trk_mem_r[k].dir == DIR_WR) begin
                    busy_wr_s[IDX_W'(trk_mem_r[k].ch)] = 1'b1;
                end else begin
                    busy_rd_s[IDX_W'(trk_mem_r[k].ch)] = 1'b1;
                end
            end else begin
                busy_rd_s = busy_rd_s;
            end
        end
    end

    assign elig_rd_s = ch_enable_i & ch_rd_pend_i & ~ch_err_r & ~busy_rd_s;
    assign elig_wr_s = ch_enable_i & ch_wr_pend_i & ~ch_err_r & ~busy_wr_s;

    v_prio_rr_arb #(.N(CHANNEL_NUM), .PRIO_W(PRIO_W)) u_arb_rd (
        .req     (elig_rd_s),
        .prio    (ch_prior_i),
        .rr_ptr  (rr_ptr_r),
        .gnt_idx (rd_idx_s),
        .gnt_vld (rd_vld_s)
    );

    v_prio_rr_arb #(.N(CHANNEL_NUM), .PRIO_W(PRIO_W)) u_arb_wr (
        .req     (elig_wr_s),
        .prio    (ch_prior_i),
        .rr_ptr  (rr_ptr_r),
        .gnt_idx (wr_idx_s),
        .gnt_vld (wr_vld_s)
    );

    // Direction choice: WRITE_FIRST breaks the tie when both sides have a winner.
    always_comb begin
        sel_vld_s = 1'b0;
        sel_ch_s  = '0;
        sel_dir_s = DIR_RD;
        if (wr_vld_s && (WRITE_FIRST || !rd_vld_s)) begin
            sel_vld_s = 1'b1;
            sel_ch_s  = wr_idx_s;
            sel_dir_s = DIR_WR;
        end else if (rd_vld_s) begin
            sel_vld_s = 1'b1;
            sel_ch_s  = rd_idx_s;
            sel_dir_s = DIR_RD;
        end else begin
            sel_vld_s = 1'b0;
        end
    end

    // Scheduler next state; OFFER is left only by handshake or channel disable.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        push_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (|ch_enable_i) begin
                    state_nxt_s = ARB;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ARB: begin
                if (!(|ch_enable_i) && empty_s) begin
                    state_nxt_s = IDLE;
                end else if (sel_vld_s && !full_s) begin
                    state_nxt_s = OFFER;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ARB;
                end
            end
            OFFER: begin
                if (xfer_ready_i) begin
                    state_nxt_s = ARB;
                    push_s      = 1'b1;
                end else if (!ch_enable_i[off_ch_r]) begin
                    state_nxt_s = ARB;
                end else begin
                    state_nxt_s = OFFER;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Tracker occupancy after this cycle's push and pop.
    always_comb begin
        if (push_s && !pop_s) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // An errored completion flags the owning channel of the popped entry.
    always_comb begin
        err_set_s = '0;
        if (pop_s && resp_err_i) begin
            err_set_s[IDX_W'(head_s.ch)] = 1'b1;
        end else begin
            err_set_s = '0;
        end
    end

    // Scheduler state, offered burst and round-robin pointer.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_r      <= IDLE;
            off_ch_r     <= '0;
            off_dir_r    <= DIR_RD;
            xfer_valid_r <= 1'b0;
            rr_ptr_r     <= '0;
            idle_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            xfer_valid_r <= (state_nxt_s == OFFER);
            idle_r       <= (state_nxt_s == IDLE) && (cnt_nxt_s == '0);
            if (load_s) begin
                off_ch_r  <= sel_ch_s;
                off_dir_r <= sel_dir_s;
            end
            if (push_s) begin
                rr_ptr_r <= (off_ch_r == IDX_LAST) ? '0 : off_ch_r + IDX_ONE;
            end
        end
    end

    // In-order outstanding-burst FIFO.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            for (int k = 0; k < MAX_OUTST; k++) begin
                trk_mem_r[k] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (push_s) begin
                trk_mem_r[wr_ptr_r] <= '{ch: CH_W_MAX'(off_ch_r), dir: off_dir_r};
                wr_ptr_r            <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            cnt_r <= cnt_nxt_s;
        end
    end

    // Completion strobe and sticky error flags; a set beats a same-cycle clear.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            done_valid_r <= 1'b0;
            done_ch_r    <= '0;
            done_dir_r   <= 1'b0;
            proto_err_r  <= 1'b0;
            ch_err_r     <= '0;
        end else begin
            done_valid_r <= pop_s;
            if (pop_s) begin
                done_ch_r  <= IDX_W'(head_s.ch);
                done_dir_r <= head_s.dir;
            end
            if (done_i && empty_s) begin
                proto_err_r <= 1'b1;
            end
            ch_err_r <= err_set_s | (ch_err_r & ch_enable_i);
        end
    end

    assign xfer_valid_o = xfer_valid_r;
    assign xfer_ch_o    = off_ch_r;
    assign xfer_dir_o   = off_dir_r;
    assign done_valid_o = done_valid_r;
    assign done_ch_o    = done_ch_r;
    assign done_dir_o   = done_dir_r;
    assign ch_err_o     = ch_err_r;
    assign proto_err_o  = proto_err_r;
    assign outst_cnt_o  = cnt_r;
    assign idle_o       = idle_r;

endmodule

// File: tb/tb_v_xfer_sched.sv
// Bench for v_xfer_sched: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference of the scheduling rules.
module tb_v_xfer_sched;

    logic            clk = 1'b0;
    logic            areset;
    logic [7:0]      en, rd_pend, wr_pend;
    logic [7:0][1:0] prio;
    logic            ready, done, rerr;

    logic            xv, xd, dv, dd, pe, idl;
    logic [2:0]      xc, dc, cnt;
    logic [7:0]      cerr;
    logic            xv2, xd2, dv2, dd2, pe2, idl2;
    logic [2:0]      xc2, dc2, cnt2;
    logic [7:0]      cerr2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {int ch; int dir;} ent_t;
    ent_t       mq[$];
    int         m_phase;   // 0 quiet, 1 choosing, 2 offering
    int         m_ch, m_dir, m_rr;
    bit [7:0]   m_err;
    bit         m_proto, e_dv, e_idle;
    int         e_dch, e_ddir;

    always #5 clk = ~clk;

    v_xfer_sched dut (
        .clk(clk), .areset(areset), .ch_enable_i(en), .ch_prior_i(prio),
        .ch_rd_pend_i(rd_pend), .ch_wr_pend_i(wr_pend), .xfer_valid_o(xv),
        .xfer_ready_i(ready), .xfer_ch_o(xc), .xfer_dir_o(xd), .done_i(done),
        .resp_err_i(rerr), .done_valid_o(dv), .done_ch_o(dc), .done_dir_o(dd),
        .ch_err_o(cerr), .proto_err_o(pe), .outst_cnt_o(cnt), .idle_o(idl)
    );

    v_xfer_sched #(.WRITE_FIRST(1'b0)) dut_rf (
        .clk(clk), .areset(areset), .ch_enable_i(en), .ch_prior_i(prio),
        .ch_rd_pend_i(rd_pend), .ch_wr_pend_i(wr_pend), .xfer_valid_o(xv2),
        .xfer_ready_i(ready), .xfer_ch_o(xc2), .xfer_dir_o(xd2), .done_i(done),
        .resp_err_i(rerr), .done_valid_o(dv2), .done_ch_o(dc2), .done_dir_o(dd2),
        .ch_err_o(cerr2), .proto_err_o(pe2), .outst_cnt_o(cnt2), .idle_o(idl2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit in_flight(input int ch, input int dir);
        foreach (mq[k]) if (mq[k].ch == ch && mq[k].dir == dir) return 1'b1;
        return 1'b0;
    endfunction

    // Spec-level choice: direction by WRITE_FIRST, then max prio, ties from m_rr upward.
    function automatic bit pick(output int ch, output int dir);
        bit [7:0] el [2];
        int best, idx;
        ch = 0; dir = 0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++)
                el[d][i] = en[i] && (d == 1 ? wr_pend[i] : rd_pend[i]) && !m_err[i] && !in_flight(i, d);
        if (el[1] != 0) dir = 1;
        else if (el[0] != 0) dir = 0;
        else return 1'b0;
        best = -1;
        for (int i = 0; i < 8; i++)
            if (el[dir][i] && int'(prio[i]) > best) best = int'(prio[i]);
        for (int k = 0; k < 8; k++) begin
            idx = (m_rr + k) % 8;
            if (el[dir][idx] && int'(prio[idx]) == best) begin
                ch = idx;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_phase = 0; m_rr = 0; m_err = '0; m_proto = 1'b0;
        e_dv = 1'b0; e_idle = 1'b0; m_ch = 0; m_dir = 0;
    endfunction

    function automatic void model_step();
        int nph, pc, pd;
        bit push;
        bit [7:0] set_m;
        ent_t e;
        nph = m_phase; push = 1'b0; set_m = '0;
        if (m_phase == 0) begin
            if (en != 0) nph = 1;
        end else if (m_phase == 1) begin
            if (en == 0 && mq.size() == 0) nph = 0;
            else if (mq.size() < 4 && pick(pc, pd)) begin
                nph = 2; m_ch = pc; m_dir = pd;
            end
        end else begin
            if (ready) begin push = 1'b1; nph = 1; end
            else if (!en[m_ch]) nph = 1;
        end
        e_dv = 1'b0;
        if (done) begin
            if (mq.size() == 0) m_proto = 1'b1;
            else begin
                e = mq.pop_front();
                e_dv = 1'b1; e_dch = e.ch; e_ddir = e.dir;
                if (rerr) set_m[e.ch] = 1'b1;
            end
        end
        if (push) begin
            mq.push_back('{m_ch, m_dir});
            m_rr = (m_ch + 1) % 8;
        end
        for (int i = 0; i < 8; i++)
            if (set_m[i]) m_err[i] = 1'b1;
            else if (!en[i]) m_err[i] = 1'b0;
        m_phase = nph;
        e_idle  = (nph == 0) && (mq.size() == 0);
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_eq("xfer_valid", xv, m_phase == 2);
        if (m_phase == 2) begin
            check_eq("xfer_ch", xc, m_ch);
            check_eq("xfer_dir", xd, m_dir);
        end
        check_eq("outst_cnt", cnt, mq.size());
        check_eq("ch_err", cerr, m_err);
        check_eq("proto_err", pe, m_proto);
        check_eq("done_valid", dv, e_dv);
        if (e_dv) begin
            check_eq("done_ch", dc, e_dch);
            check_eq("done_dir", dd, e_ddir);
        end
        check_eq("idle", idl, e_idle);
    endtask

    // Asynchronous reset pulse taken mid-cycle; outputs must clear at once.
    task automatic reset_pulse(input string tag);
        areset = 1'b0;
        #2;
        check_eq(tag, {xv, xc, xd, dv, dc, dd, cerr, pe, cnt, idl}, 32'd0);
        model_reset();
        #1;
        areset = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !xv; i++) cycle();
        check_eq(tag, xv, 1'b1);
    endtask

    task automatic grab(input string tag, output int ch, output int dir);
        wait_valid(tag);
        ch = xc; dir = xd;
        ready = 1'b1;
        cycle();
        ready = 1'b0;
    endtask

    task automatic pulse_done(input bit with_err);
        done = 1'b1; rerr = with_err;
        cycle();
        done = 1'b0; rerr = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && mq.size() > 0; i++) pulse_done(1'b0);
    endtask

    initial begin
        int ch, dir;
        int alt [4] = '{1, 5, 1, 5};
        en = '0; rd_pend = '0; wr_pend = '0; prio = '0;
        ready = 1'b0; done = 1'b0; rerr = 1'b0;
        areset = 1'b0;
        model_reset();
        #12;
        check_eq("reset_outs", {xv, xc, xd, dv, dc, dd, cerr, pe, cnt, idl}, 32'd0);
        areset = 1'b1;
        cycle();
        check_eq("idle_after_reset", idl, 1'b1);

        // single read request on ch2
        en = 8'hFF; rd_pend = 8'h04;
        cycle();
        cycle();
        check_eq("t1_valid", xv, 1'b1);
        check_eq("t1_ch", xc, 3'd2);
        check_eq("t1_dir", xd, 1'b0);
        ready = 1'b1;
        cycle();
        ready = 1'b0; rd_pend = 8'h00;
        check_eq("t1_cnt", cnt, 3'd1);
        pulse_done(1'b0);
        check_eq("t1_done_ch", dc, 3'd2);

        // priority first, then round-robin among equals
        prio[1] = 2'd3; prio[5] = 2'd1; rd_pend = 8'h22;
        grab("t2_reach_a", ch, dir);
        check_eq("t2_prio_first", ch, 1);
        grab("t2_reach_b", ch, dir);
        rd_pend = 8'h00;
        check_eq("t2_prio_second", ch, 5);
        drain();
        prio = '0;
        for (int g = 0; g < 4; g++) begin
            rd_pend = 8'h22;
            grab("t2_reach_rr", ch, dir);
            rd_pend = 8'h00;
            check_eq("t2_rr_order", ch, alt[g]);
            pulse_done(1'b0);
        end

        // read vs write on the same cycle, both WRITE_FIRST settings
        reset_pulse("t3_reset");
        en = 8'hFF; rd_pend = 8'h01; wr_pend = 8'h08;
        wait_valid("t3_reach");
        check_eq("t3_wf_ch", xc, 3'd3);
        check_eq("t3_wf_dir", xd, 1'b1);
        check_eq("t3_rf_ch", xc2, 3'd0);
        check_eq("t3_rf_dir", xd2, 1'b0);
        grab("t3_grab", ch, dir);
        rd_pend = 8'h00; wr_pend = 8'h00;
        drain();

        // tracker full stalls offers until a completion frees a slot
        rd_pend = 8'h1F;
        for (int g = 0; g < 4; g++) grab("t4_fill", ch, dir);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("t4_full_no_valid", xv, 1'b0);
        end
        check_eq("t4_cnt_full", cnt, 3'd4);
        pulse_done(1'b0);
        wait_valid("t4_resume");
        grab("t4_grab", ch, dir);
        rd_pend = 8'h00;
        drain();

        // errored completion blocks ch6 until its enable drops
        rd_pend = 8'h40;
        grab("t5_reach", ch, dir);
        check_eq("t5_ch", ch, 6);
        pulse_done(1'b1);
        check_eq("t5_done_valid", dv, 1'b1);
        check_eq("t5_done_ch", dc, 3'd6);
        check_eq("t5_err6", cerr[6], 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check_eq("t5_blocked", xv, 1'b0);
        end
        en = 8'hBF;
        cycle();
        check_eq("t5_err_clear", cerr[6], 1'b0);
        en = 8'hFF;
        wait_valid("t5_reoffer");
        check_eq("t5_reoffer_ch", xc, 3'd6);
        grab("t5_grab", ch, dir);
        rd_pend = 8'h00;
        drain();

        // completion with nothing outstanding, then reset during an offer
        pulse_done(1'b0);
        check_eq("t6_proto", pe, 1'b1);
        check_eq("t6_cnt", cnt, 3'd0);
        rd_pend = 8'h01;
        wait_valid("t6_reach");
        reset_pulse("t6_reset_mid_offer");

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) en = 8'h00;
            else if ($urandom_range(0, 5) == 0) en = 8'($urandom);
            else en = 8'hFF;
            rd_pend = 8'($urandom);
            wr_pend = 8'($urandom);
            prio    = 16'($urandom);
            ready   = 1'($urandom_range(0, 1));
            done    = ($urandom_range(0, 3) == 0);
            rerr    = done && ($urandom_range(0, 7) == 0);
            cycle();
        end
        done = 1'b0; rerr = 1'b0; ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
